// File: rtl/voice_mixer_pwm.sv
// Eight-voice mixer with per-voice linear attack/release envelopes feeding
// a single first-order PWM DAC on the speaker pin.
module voice_mixer_pwm #(
   parameter int unsigned NUM_VOICES      = 8,
   parameter int unsigned ENV_BITS        = 4,
   parameter int unsigned ENV_STEP_CYCLES = 25000,
   parameter int unsigned PWM_BITS        = 8
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_VOICES-1:0]                    voice_en,
   input  logic [NUM_VOICES-1:0]                    voice_sq,
   input  logic                                     master_mute,
   output logic                                     pwm_out,
   output logic [ENV_BITS+$clog2(NUM_VOICES)-1:0]   level,
   output logic                                     sample_strobe,
   output logic [$clog2(NUM_VOICES):0]              active_count
);

   localparam int unsigned CNT_BITS = $clog2(NUM_VOICES);
   localparam int unsigned LVL_BITS = ENV_BITS + CNT_BITS;
   localparam int unsigned ACT_BITS = CNT_BITS + 1;
   localparam int unsigned PRE_BITS = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;

   logic [PRE_BITS-1:0] prescaler;
   logic                env_tick;
   logic [ENV_BITS-1:0] env [NUM_VOICES];
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                period_end;
   logic [LVL_BITS-1:0] mix_sum;
   logic [ACT_BITS-1:0] nz_count;

   assign env_tick   = (prescaler == PRE_BITS'(ENV_STEP_CYCLES - 1));
   assign period_end = (pwm_cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler <= '0;
      end else if (env_tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PRE_BITS'(1);
      end
   end

   // Envelopes move one step per tick toward max (key held) or zero (released).
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (rst) begin
            env[i] <= '0;
         end else if (env_tick) begin
            if (voice_en[i] && (env[i] != '1)) begin
               env[i] <= env[i] + ENV_BITS'(1);
            end else if (!voice_en[i] && (env[i] != '0)) begin
               env[i] <= env[i] - ENV_BITS'(1);
            end
         end
      end
   end

   always_comb begin
      mix_sum  = '0;
      nz_count = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (voice_sq[i]) begin
            mix_sum = mix_sum + LVL_BITS'(env[i]);
         end
         if (env[i] != '0) begin
            nz_count = nz_count + ACT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_count <= '0;
      end else begin
         active_count <= nz_count;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Level is captured on the last count of a period so a whole period uses one duty.
   always_ff @(posedge clk) begin
      if (rst) begin
         level         <= '0;
         sample_strobe <= 1'b0;
      end else begin
         sample_strobe <= period_end;
         if (period_end) begin
            level <= mix_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= (pwm_cnt < PWM_BITS'(level)) && !master_mute;
      end
   end

endmodule
